// File: rtl/multififo_pkg.sv
// rtl/multififo_pkg.sv - shared types, constants and round-robin index helper for the write scheduler
package multififo_pkg;

  typedef enum logic {
    RR   = 1'b0,
    HOLD = 1'b1
  } sched_state_t;

  localparam int LENW = 4;

  // Index of the requester 'off' positions after 'base' in a ring of n requesters.
  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/multififo_wr_sched_rr_pick.sv
// rtl/multififo_wr_sched_rr_pick.sv - rotate-priority find-first starting at the round-robin pointer
module rr_pick
  import multififo_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] rr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] j;

  // Walk rr, rr+1, ... and latch the first set bit.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'(rr_index(32'(rr), 32'(k), 32'(N)));
      if (!found && vec[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multififo_wr_sched.sv
// rtl/multififo_wr_sched.sv - round-robin burst write scheduler for the multi-write FIFO; MULTIFIFO_SCHED_STATS_EN adds grant_cnt
module multififo_wr_sched
  import multififo_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 32,
  parameter int MAXW   = 10,
  parameter int DEPTH  = 8,
  parameter int STARVE = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        softreset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*LENW-1:0]        req_len,
  input  logic [NREQ*MAXW*WIDTH-1:0]  req_data,
  output logic [NREQ-1:0]             req_ack,
  output logic [3:0]                  fifo_writes,
  output logic [MAXW*WIDTH-1:0]       fifo_din,
  input  logic [15:0]                 fifo_frees,
  input  logic                        fifo_taken,
  output logic                        hold,
  output logic                        err_len,
  output logic                        err_overflow
`ifdef MULTIFIFO_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]          grant_cnt
`endif
);

  localparam int IW   = $clog2(NREQ);
  localparam int MAXL = (MAXW < DEPTH) ? MAXW : DEPTH;
  localparam int SW   = $clog2(STARVE + 1);
  localparam int BW   = MAXW * WIDTH;
  localparam logic [LENW-1:0] MAXL_L = LENW'(MAXL);

  sched_state_t        state, state_n;
  logic [IW-1:0]       rr, rr_n;
  logic [SW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       sidx, sidx_n;

  logic [16:0]         eff_raw, eff;
  logic [LENW-1:0]     lens [NREQ];
  logic [NREQ-1:0]     legal, fits, elig, sel_vec, head_vec, rr_oh;
  logic [IW-1:0]       pick_idx, head_idx;
  logic                pick_found, head_found;
  logic                blocked, grant, drop, starving;
  logic [BW-1:0]       din_n;

  // The in-flight write has not yet landed in fifo_frees, so subtract it; clamp at zero.
  assign eff_raw = {1'b0, fifo_frees} - {13'd0, fifo_writes};
  assign eff     = eff_raw[16] ? '0 : eff_raw;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign lens[g]  = req_len[g*LENW +: LENW];
    assign legal[g] = (lens[g] != '0) && (lens[g] <= MAXL_L);
    assign fits[g]  = ({13'd0, lens[g]} <= eff);
  end

  assign elig     = req_valid & legal & fits;
  assign head_vec = req_valid & legal;
  assign rr_oh    = NREQ'(1) << rr;

  // Illegal lengths stay selectable so they get flushed; in HOLD only the starving head may win.
  assign sel_vec = (state == HOLD) ? (elig & rr_oh) : (req_valid & (~legal | fits));

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .vec   (sel_vec),
    .rr    (rr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // The head is the first valid, legal requester from rr: the one a large burst starves behind.
  rr_pick #(.N(NREQ), .IW(IW)) u_head (
    .vec   (head_vec),
    .rr    (rr),
    .idx   (head_idx),
    .found (head_found)
  );

  assign blocked = rst | softreset;
  assign grant   = !blocked && pick_found && legal[pick_idx];
  assign drop    = !blocked && pick_found && !legal[pick_idx];
  assign req_ack = (grant || drop) ? (NREQ'(1) << pick_idx) : '0;
  assign err_len = drop;
  assign hold    = (state == HOLD);

  // Next-state: pointer advance, starve counting and the RR/HOLD transitions.
  always_comb begin
    state_n  = state;
    rr_n     = rr;
    cnt_n    = '0;
    sidx_n   = sidx;
    starving = head_found && !fits[head_idx];
    case (state)
      RR: begin
        if (starving) begin
          if ((cnt != '0) && (head_idx == sidx)) cnt_n = cnt + 1'b1;
          else                                   cnt_n = SW'(1);
          sidx_n = head_idx;
        end
        if (grant) rr_n = IW'(rr_index(32'(pick_idx), 32'd1, 32'(NREQ)));
        if (starving && (cnt_n == SW'(STARVE))) begin
          state_n = HOLD;
          rr_n    = head_idx;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        if (grant) begin
          state_n = RR;
          rr_n    = IW'(rr_index(32'(rr), 32'd1, 32'(NREQ)));
        end else if (!req_valid[rr]) begin
          state_n = RR;
        end
      end
      default: state_n = RR;
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RR;
      rr    <= '0;
      cnt   <= '0;
      sidx  <= '0;
    end else if (softreset) begin
      state <= RR;
      rr    <= '0;
      cnt   <= '0;
      sidx  <= '0;
    end else begin
      state <= state_n;
      rr    <= rr_n;
      cnt   <= cnt_n;
      sidx  <= sidx_n;
    end
  end

  // Granted burst words with lanes beyond len forced to zero.
  always_comb begin
    din_n = '0;
    for (int l = 0; l < MAXW; l++) begin
      if (l < {28'd0, lens[pick_idx]})
        din_n[l*WIDTH +: WIDTH] = req_data[(int'(pick_idx)*MAXW + l)*WIDTH +: WIDTH];
    end
  end

  // Register stage toward the FIFO write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_writes <= '0;
      fifo_din    <= '0;
    end else if (softreset || !grant) begin
      fifo_writes <= '0;
      fifo_din    <= '0;
    end else begin
      fifo_writes <= lens[pick_idx];
      fifo_din    <= din_n;
    end
  end

  // Sticky flag: the FIFO refused a write we issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      err_overflow <= 1'b0;
    else if (softreset)                           err_overflow <= 1'b0;
    else if ((fifo_writes != '0) && !fifo_taken)  err_overflow <= 1'b1;
  end

`ifdef MULTIFIFO_SCHED_STATS_EN
  // Per-requester granted burst counters, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (softreset) begin
      grant_cnt <= '0;
    end else if (grant) begin
      for (int i = 0; i < NREQ; i++) begin
        if (IW'(i) == pick_idx) grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multififo_wr_sched.sv
// tb/tb_multififo_wr_sched.sv - table-driven and sequence checks for multififo_wr_sched
module tb_multififo_wr_sched;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           softreset = 1'b0;
  logic [3:0]     req_valid = '0;
  logic [15:0]    req_len = '0;
  logic [1279:0]  req_data = '0;
  logic [3:0]     req_ack;
  logic [3:0]     fifo_writes;
  logic [319:0]   fifo_din;
  logic [15:0]    fifo_frees = 16'd8;
  logic           fifo_taken = 1'b1;
  logic           hold;
  logic           err_len;
  logic           err_overflow;
`ifdef MULTIFIFO_SCHED_STATS_EN
  logic [63:0]    grant_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  multififo_wr_sched #(
    .NREQ(4), .WIDTH(32), .MAXW(10), .DEPTH(8), .STARVE(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .softreset    (softreset),
    .req_valid    (req_valid),
    .req_len      (req_len),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .fifo_writes  (fifo_writes),
    .fifo_din     (fifo_din),
    .fifo_frees   (fifo_frees),
    .fifo_taken   (fifo_taken),
    .hold         (hold),
    .err_len      (err_len),
    .err_overflow (err_overflow)
`ifdef MULTIFIFO_SCHED_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [15:0] lens;
    logic [15:0] frees;
    logic [3:0]  ack;
    logic        err;
    logic [3:0]  wr;
    logic        hld;
  } row_t;

  row_t tbl [18];

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] l, input logic [15:0] fr);
    req_valid  = v;
    req_len    = l;
    fifo_frees = fr;
  endtask

  // Move to the next falling edge and let combinational outputs settle.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [319:0] exp_din;

  initial begin
    for (int i = 0; i < 4; i++)
      for (int w = 0; w < 10; w++)
        req_data[(i*10 + w)*32 +: 32] = 32'hD000_0000 + 32'(i*256 + w);

    tbl[0]  = '{4'b0011, 16'h0033, 16'd8, 4'b0001, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{4'b0010, 16'h0030, 16'd8, 4'b0010, 1'b0, 4'd3, 1'b0};
    tbl[2]  = '{4'b0000, 16'h0000, 16'd8, 4'b0000, 1'b0, 4'd3, 1'b0};
    tbl[3]  = '{4'b0100, 16'h0600, 16'd8, 4'b0100, 1'b0, 4'd0, 1'b0};
    tbl[4]  = '{4'b1000, 16'h4000, 16'd8, 4'b0000, 1'b0, 4'd6, 1'b0};
    tbl[5]  = '{4'b1000, 16'h4000, 16'd8, 4'b1000, 1'b0, 4'd0, 1'b0};
    tbl[6]  = '{4'b0000, 16'h0000, 16'd8, 4'b0000, 1'b0, 4'd4, 1'b0};
    tbl[7]  = '{4'b1000, 16'h0000, 16'd8, 4'b1000, 1'b1, 4'd0, 1'b0};
    tbl[8]  = '{4'b1000, 16'hB000, 16'd8, 4'b1000, 1'b1, 4'd0, 1'b0};
    tbl[9]  = '{4'b1000, 16'h9000, 16'd8, 4'b1000, 1'b1, 4'd0, 1'b0};
    tbl[10] = '{4'b1000, 16'h8000, 16'd8, 4'b1000, 1'b0, 4'd0, 1'b0};
    tbl[11] = '{4'b0000, 16'h0000, 16'd8, 4'b0000, 1'b0, 4'd8, 1'b0};
    tbl[12] = '{4'b1111, 16'h1111, 16'd8, 4'b0001, 1'b0, 4'd0, 1'b0};
    tbl[13] = '{4'b1110, 16'h1110, 16'd8, 4'b0010, 1'b0, 4'd1, 1'b0};
    tbl[14] = '{4'b1100, 16'h1100, 16'd8, 4'b0100, 1'b0, 4'd1, 1'b0};
    tbl[15] = '{4'b1000, 16'h1000, 16'd8, 4'b1000, 1'b0, 4'd1, 1'b0};
    tbl[16] = '{4'b0001, 16'h0001, 16'd0, 4'b0000, 1'b0, 4'd1, 1'b0};
    tbl[17] = '{4'b0000, 16'h0000, 16'd8, 4'b0000, 1'b0, 4'd0, 1'b0};

    // Reset state.
    @(negedge clk);
    #2;
    chk("rst_writes", 320'(fifo_writes), 320'(4'd0));
    chk("rst_din", fifo_din, '0);
    chk("rst_hold", 320'(hold), 320'(1'b0));
    chk("rst_ovf", 320'(err_overflow), 320'(1'b0));
    chk("rst_ack", 320'(req_ack), 320'(4'd0));
    @(negedge clk);
    rst = 1'b0;

    // Cycle-by-cycle vectors.
    for (int r = 0; r < 18; r++) begin
      next_cyc();
      drive(tbl[r].v, tbl[r].lens, tbl[r].frees);
      #2;
      chk($sformatf("row%0d_ack", r), 320'(req_ack), 320'(tbl[r].ack));
      chk($sformatf("row%0d_err_len", r), 320'(err_len), 320'(tbl[r].err));
      chk($sformatf("row%0d_writes", r), 320'(fifo_writes), 320'(tbl[r].wr));
      chk($sformatf("row%0d_hold", r), 320'(hold), 320'(tbl[r].hld));
    end

    // Starvation: req0 len 8 never fits in 5 free, req1 len 1 keeps winning.
    pulse_reset();
    drive(4'b0011, 16'h0018, 16'd5);
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("starve_c%0d_ack", c), 320'(req_ack), 320'(4'b0010));
      chk($sformatf("starve_c%0d_hold", c), 320'(hold), 320'(1'b0));
      next_cyc();
    end
    for (int c = 4; c < 6; c++) begin
      #2;
      chk($sformatf("starve_c%0d_ack", c), 320'(req_ack), 320'(4'b0000));
      chk($sformatf("starve_c%0d_hold", c), 320'(hold), 320'(1'b1));
      next_cyc();
    end
    fifo_frees = 16'd8;
    #2;
    chk("starve_release_ack", 320'(req_ack), 320'(4'b0001));
    chk("starve_release_hold", 320'(hold), 320'(1'b1));
    next_cyc();
    drive(4'b0010, 16'h0010, 16'd8);
    #2;
    chk("starve_after_hold", 320'(hold), 320'(1'b0));
    chk("starve_after_writes", 320'(fifo_writes), 320'(4'd8));
    chk("starve_after_ack", 320'(req_ack), 320'(4'b0000));

    // Overflow flag and softreset.
    pulse_reset();
    drive(4'b0001, 16'h0002, 16'd8);
    #2;
    chk("ovf_grant_ack", 320'(req_ack), 320'(4'b0001));
    next_cyc();
    req_valid = '0;
    fifo_taken = 1'b0;
    #2;
    exp_din = '0;
    exp_din[31:0]  = 32'hD000_0000;
    exp_din[63:32] = 32'hD000_0001;
    chk("ovf_writes", 320'(fifo_writes), 320'(4'd2));
    chk("ovf_din", fifo_din, exp_din);
    chk("ovf_before", 320'(err_overflow), 320'(1'b0));
    next_cyc();
    fifo_taken = 1'b1;
    #2;
    chk("ovf_set", 320'(err_overflow), 320'(1'b1));
    next_cyc();
    #2;
    chk("ovf_sticky", 320'(err_overflow), 320'(1'b1));
    softreset = 1'b1;
    drive(4'b0011, 16'h0011, 16'd8);
    #1;
    chk("softreset_no_ack", 320'(req_ack), 320'(4'b0000));
    next_cyc();
    softreset = 1'b0;
    #2;
    chk("softreset_ovf", 320'(err_overflow), 320'(1'b0));
    chk("softreset_writes", 320'(fifo_writes), 320'(4'd0));
    chk("softreset_din", fifo_din, '0);
    chk("softreset_hold", 320'(hold), 320'(1'b0));
    chk("softreset_rr0", 320'(req_ack), 320'(4'b0001));

    // Asynchronous reset with a write in flight.
    next_cyc();
    drive(4'b0001, 16'h0003, 16'd8);
    #2;
    chk("async_pre_ack", 320'(req_ack), 320'(4'b0001));
    next_cyc();
    req_valid = '0;
    #1;
    chk("async_inflight", 320'(fifo_writes), 320'(4'd3));
    rst = 1'b1;
    #1;
    chk("async_writes", 320'(fifo_writes), 320'(4'd0));
    chk("async_din", fifo_din, '0);
    next_cyc();
    rst = 1'b0;
    drive(4'b0011, 16'h0011, 16'd8);
    #2;
    chk("async_rr0", 320'(req_ack), 320'(4'b0001));
    next_cyc();
    req_valid = '0;
    #2;
    chk("async_after_writes", 320'(fifo_writes), 320'(4'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
